pong_game_ctrl: RTL and testbench

Game sequencer for the pong datapath; runs on the pixel clock. Frame progress is a one-cycle frame_tick strobe derived from vsync.
Drives the datapath's ball reset/run controls and serve direction. Keeps both scores, detects the winner and exposes state for the score/overlay renderer.
Sits between the input conditioning (start button, miss pulses from the ball/edge logic) and the pong datapath.

---
 rtl/pong_pkg.sv | 24 ++
 rtl/pong_edge_detect.sv | 32 +++
 rtl/pong_game_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_pong_game_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// pong_pkg: definitions shared by the pong game controller and the
// score/overlay renderer.
//   state_t              - game sequencer state encoding (also exported
//                          on the controller's debug/overlay port)
//   DIR_LEFT/DIR_RIGHT   - serve direction encoding
//   DEFAULT_WIN_SCORE    - default points needed to win a match
//   DEFAULT_SERVE_FRAMES - default frames the ball waits before a serve
package pong_pkg;

  typedef enum logic [2:0] {
    ATTRACT  = 3'd0,
    SERVE    = 3'd1,
    PLAY     = 3'd2,
    POINT    = 3'd3,
    GAMEOVER = 3'd4
  } state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam int DEFAULT_WIN_SCORE    = 7;
  localparam int DEFAULT_SERVE_FRAMES = 60;

endpackage

// File: rtl/pong_edge_detect.sv
// pong_edge_detect: registered rising-edge detector for an already
// synchronised button level.
// Ports:
//   clk   in  clock
//   reset in  synchronous, active-high reset
//   level in  synchronised button level
//   rise  out high for the cycle in which level is 1 and its previous
//             registered sample was 0
// The previous sample resets to RESET_LEVEL; with the default of 1 a
// button already held through reset produces no edge.
module pong_edge_detect #(
  parameter logic RESET_LEVEL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev <= RESET_LEVEL;
    end else begin
      prev <= level;
    end
  end

  assign rise = level & ~prev;

endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: game sequencer for the pong datapath (pixel clock domain).
// Sequences ATTRACT -> SERVE -> PLAY -> POINT -> (SERVE | GAMEOVER),
// keeps both scores, detects the winner and drives the datapath's ball
// controls. All outputs are registered.
// Ports:
//   clk        in  pixel clock
//   reset      in  synchronous, active-high reset
//   frame_tick in  one-cycle pulse per frame
//   start_btn  in  synchronised start/pause button level
//   miss_left  in  pulse: ball passed the left paddle (right player scores)
//   miss_right in  pulse: ball passed the right paddle (left player scores)
//   ball_reset out hold ball at centre
//   ball_run   out datapath may advance the ball
//   serve_dir  out serve direction (0 = left, 1 = right)
//   score1     out left player score
//   score2     out right player score
//   game_over  out match finished
//   winner     out 0 = left, 1 = right; valid while game_over
//   paused     out play paused
//   state      out current state encoding
// Build option: define PONG_PAUSE_EN to let a start press in PLAY toggle a
// pause; without it paused stays 0 and start presses in PLAY are ignored.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE    = DEFAULT_WIN_SCORE,
  parameter int SERVE_FRAMES = DEFAULT_SERVE_FRAMES,
  parameter int SCORE_W      = 4,
  parameter int CNT_W        = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               start_btn,
  input  logic               miss_left,
  input  logic               miss_right,
  output logic               ball_reset,
  output logic               ball_run,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic               game_over,
  output logic               winner,
  output logic               paused,
  output logic [2:0]         state
);

  localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);
  localparam logic [CNT_W-1:0]   SERVE_LOAD = CNT_W'(SERVE_FRAMES - 1);

  state_t               state_q, state_n;
  logic [CNT_W-1:0]     cnt_q, cnt_n;
  logic [SCORE_W-1:0]   score1_n, score2_n;
  logic                 serve_dir_n, game_over_n, winner_n, paused_n;
  logic                 ball_reset_n, ball_run_n;
  logic                 start_edge;

  pong_edge_detect #(
    .RESET_LEVEL(1'b1)
  ) u_start_edge (
    .clk  (clk),
    .reset(reset),
    .level(start_btn),
    .rise (start_edge)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ATTRACT;
      cnt_q      <= '0;
      score1     <= '0;
      score2     <= '0;
      serve_dir  <= DIR_LEFT;
      game_over  <= 1'b0;
      winner     <= 1'b0;
      paused     <= 1'b0;
      ball_reset <= 1'b1;
      ball_run   <= 1'b0;
    end else begin
      state_q    <= state_n;
      cnt_q      <= cnt_n;
      score1     <= score1_n;
      score2     <= score2_n;
      serve_dir  <= serve_dir_n;
      game_over  <= game_over_n;
      winner     <= winner_n;
      paused     <= paused_n;
      ball_reset <= ball_reset_n;
      ball_run   <= ball_run_n;
    end
  end

  always_comb begin
    state_n     = state_q;
    cnt_n       = cnt_q;
    score1_n    = score1;
    score2_n    = score2;
    serve_dir_n = serve_dir;
    game_over_n = game_over;
    winner_n    = winner;
`ifdef PONG_PAUSE_EN
    paused_n    = paused;
`else
    paused_n    = 1'b0;
`endif

    unique case (state_q)
      ATTRACT, GAMEOVER: begin
        if (start_edge) begin
          state_n     = SERVE;
          cnt_n       = SERVE_LOAD;
          score1_n    = '0;
          score2_n    = '0;
          serve_dir_n = DIR_LEFT;
          game_over_n = 1'b0;
        end
      end

      // The counter holds the number of further ticks to wait, so the
      // tick that finds it at zero is the SERVE_FRAMES-th one.
      SERVE: begin
        if (frame_tick) begin
          if (cnt_q == '0) begin
            state_n = PLAY;
          end else begin
            cnt_n = cnt_q - CNT_W'(1);
          end
        end
      end

      // A miss takes priority over a pause toggle in the same cycle;
      // leaving PLAY clears paused anyway.
      PLAY: begin
        if (!paused && (miss_left || miss_right)) begin
          state_n = POINT;
          if (miss_left && miss_right) begin
            serve_dir_n = ~serve_dir;
          end else if (miss_left) begin
            score2_n    = score2 + SCORE_W'(1);
            serve_dir_n = DIR_LEFT;
          end else begin
            score1_n    = score1 + SCORE_W'(1);
            serve_dir_n = DIR_RIGHT;
          end
`ifdef PONG_PAUSE_EN
        end else if (start_edge) begin
          paused_n = ~paused;
`endif
        end
      end

      POINT: begin
        if (score1 == WIN_VAL || score2 == WIN_VAL) begin
          state_n     = GAMEOVER;
          game_over_n = 1'b1;
          winner_n    = (score2 == WIN_VAL);
        end else begin
          state_n = SERVE;
          cnt_n   = SERVE_LOAD;
        end
      end

      default: begin
        state_n = ATTRACT;
      end
    endcase

    if (state_n != PLAY) begin
      paused_n = 1'b0;
    end

    // Ball controls are derived from the next state so they register in
    // step with it; a paused ball is frozen in place, not recentred.
    ball_reset_n = (state_n != PLAY);
    ball_run_n   = (state_n == PLAY) && !paused_n;
  end

  assign state = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: scoreboard bench for pong_game_ctrl.
// Each stimulus cycle runs a behavioural game model and queues the
// outputs expected after the next clock edge; a monitor pops and compares
// them on every falling edge.
module tb_pong_game_ctrl;

  localparam int WIN      = 2;
  localparam int SFRAMES  = 3;
  localparam int SW       = 4;
  localparam int CW       = 8;

  localparam int M_ATTRACT  = 0;
  localparam int M_SERVE    = 1;
  localparam int M_PLAY     = 2;
  localparam int M_POINT    = 3;
  localparam int M_GAMEOVER = 4;

`ifdef PONG_PAUSE_EN
  localparam bit PAUSE_ON = 1'b1;
`else
  localparam bit PAUSE_ON = 1'b0;
`endif

  typedef struct {
    logic          ball_reset;
    logic          ball_run;
    logic          serve_dir;
    logic [SW-1:0] score1;
    logic [SW-1:0] score2;
    logic          game_over;
    logic          winner;
    logic          paused;
    logic [2:0]    state;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          frame_tick = 1'b0;
  logic          start_btn = 1'b0;
  logic          miss_left = 1'b0;
  logic          miss_right = 1'b0;
  logic          ball_reset, ball_run, serve_dir, game_over, winner, paused;
  logic [SW-1:0] score1, score2;
  logic [2:0]    state;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Behavioural game model
  int m_phase = M_ATTRACT;
  int m_ticks_left = 0;
  int m_s1 = 0;
  int m_s2 = 0;
  bit m_dir = 1'b0;
  bit m_go = 1'b0;
  bit m_win = 1'b0;
  bit m_paused = 1'b0;
  bit m_prev = 1'b1;

  pong_game_ctrl #(
    .WIN_SCORE   (WIN),
    .SERVE_FRAMES(SFRAMES),
    .SCORE_W     (SW),
    .CNT_W       (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .frame_tick(frame_tick),
    .start_btn (start_btn),
    .miss_left (miss_left),
    .miss_right(miss_right),
    .ball_reset(ball_reset),
    .ball_run  (ball_run),
    .serve_dir (serve_dir),
    .score1    (score1),
    .score2    (score2),
    .game_over (game_over),
    .winner    (winner),
    .paused    (paused),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic modelStep(input bit rst, input bit btn, input bit tick,
                           input bit ml, input bit mr);
    bit rise;
    if (rst) begin
      m_phase = M_ATTRACT; m_ticks_left = 0; m_s1 = 0; m_s2 = 0;
      m_dir = 1'b0; m_go = 1'b0; m_win = 1'b0; m_paused = 1'b0; m_prev = 1'b1;
      return;
    end
    rise   = btn && !m_prev;
    m_prev = btn;
    case (m_phase)
      M_ATTRACT, M_GAMEOVER: begin
        if (rise) begin
          m_s1 = 0; m_s2 = 0; m_dir = 1'b0; m_go = 1'b0;
          m_ticks_left = SFRAMES;
          m_phase = M_SERVE;
        end
      end
      M_SERVE: begin
        if (tick) begin
          m_ticks_left--;
          if (m_ticks_left == 0) m_phase = M_PLAY;
        end
      end
      M_PLAY: begin
        if (!m_paused && (ml || mr)) begin
          if (ml && mr) m_dir = !m_dir;
          else if (ml) begin m_s2++; m_dir = 1'b0; end
          else begin m_s1++; m_dir = 1'b1; end
          m_phase  = M_POINT;
          m_paused = 1'b0;
        end else if (PAUSE_ON && rise) begin
          m_paused = !m_paused;
        end
      end
      M_POINT: begin
        if (m_s1 == WIN || m_s2 == WIN) begin
          m_phase = M_GAMEOVER; m_go = 1'b1; m_win = (m_s2 == WIN);
        end else begin
          m_phase = M_SERVE; m_ticks_left = SFRAMES;
        end
      end
      default: m_phase = M_ATTRACT;
    endcase
  endtask

  task automatic applyStimulus(input bit rst, input bit btn, input bit tick,
                               input bit ml, input bit mr);
    exp_t e;
    @(negedge clk);
    #1;
    reset = rst; start_btn = btn; frame_tick = tick;
    miss_left = ml; miss_right = mr;
    modelStep(rst, btn, tick, ml, mr);
    e.ball_reset = (m_phase != M_PLAY);
    e.ball_run   = (m_phase == M_PLAY) && !m_paused;
    e.serve_dir  = m_dir;
    e.score1     = SW'(m_s1);
    e.score2     = SW'(m_s2);
    e.game_over  = m_go;
    e.winner     = m_win;
    e.paused     = m_paused;
    e.state      = 3'(m_phase);
    exp_q.push_back(e);
  endtask

  task automatic checkField(input string name, input int act, input int exp);
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    vectors++;
    checkField("ball_reset", int'(ball_reset), int'(e.ball_reset));
    checkField("ball_run",   int'(ball_run),   int'(e.ball_run));
    checkField("serve_dir",  int'(serve_dir),  int'(e.serve_dir));
    checkField("score1",     int'(score1),     int'(e.score1));
    checkField("score2",     int'(score2),     int'(e.score2));
    checkField("game_over",  int'(game_over),  int'(e.game_over));
    checkField("paused",     int'(paused),     int'(e.paused));
    checkField("state",      int'(state),      int'(e.state));
    if (e.game_over) checkField("winner", int'(winner), int'(e.winner));
  endtask

  // Monitor: every falling edge the DUT presents a fresh registered output.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) checkOutput(exp_q.pop_front());
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, start_btn, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pressStart();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, start_btn, 1'b1, 1'b0, 1'b0);
      idle(2);
    end
  endtask

  task automatic miss(input bit ml, input bit mr);
    applyStimulus(1'b0, start_btn, 1'b0, ml, mr);
    idle(3);
  endtask

  initial begin
    bit rb, rt, rl, rr, rs;
    // Button held through reset must not start a game.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(100);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    pressStart();
    frames(SFRAMES);
    miss(1'b0, 1'b1);
    frames(SFRAMES);
    miss(1'b1, 1'b1);
    frames(SFRAMES);
    miss(1'b1, 1'b0);
    frames(SFRAMES);
    miss(1'b1, 1'b0);
    idle(5);
    pressStart();
    frames(SFRAMES);
    // Pause, ignored miss, resume, then pause again and reset.
    pressStart();
    miss(1'b1, 1'b0);
    pressStart();
    pressStart();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);

    for (int i = 0; i < 4000; i++) begin
      rb = ($urandom_range(0, 15) == 0) ? ~start_btn : start_btn;
      rt = ($urandom_range(0, 3) == 0);
      rl = ($urandom_range(0, 9) == 0);
      rr = ($urandom_range(0, 9) == 0);
      rs = ($urandom_range(0, 499) == 0);
      applyStimulus(rs, rb, rt, rl, rr);
    end

    @(negedge clk);
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
